// File: rtl/data_multiplex.sv
// rtl/data_multiplex.sv - time-division mux rotating three 8-bit sources onto one registered output
module data_multiplex (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] DS1,
  input  logic [7:0] DS2,
  input  logic [7:0] DS3,
  input  logic [1:0] mode,
  input  logic [3:0] switch_clk_cycles,
  output logic [7:0] output_data
);

  localparam logic [1:0] SEL_DS1 = 2'd0;
  localparam logic [1:0] SEL_DS2 = 2'd1;
  localparam logic [1:0] SEL_DS3 = 2'd2;

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_FWD    = 2'b01;
  localparam logic [1:0] MODE_REV    = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] out_q, out_d;

  logic [3:0] neff_m1;
  logic [1:0] first_sel, second_sel, next_sel;
  logic [7:0] cur_data, first_data;

  always_comb begin
    // A dwell of 0 behaves as 1, so the terminal count is 0 in both cases
    neff_m1 = (switch_clk_cycles == 4'd0) ? 4'd0 : switch_clk_cycles - 4'd1;

    case (sel_q)
      SEL_DS2: cur_data = DS2;
      SEL_DS3: cur_data = DS3;
      default: cur_data = DS1;
    endcase

    if (mode == MODE_REV) begin
      first_sel  = SEL_DS3;
      first_data = DS3;
      second_sel = SEL_DS2;
      case (sel_q)
        SEL_DS3: next_sel = SEL_DS2;
        SEL_DS2: next_sel = SEL_DS1;
        default: next_sel = SEL_DS3;
      endcase
    end else begin
      first_sel  = SEL_DS1;
      first_data = DS1;
      second_sel = SEL_DS2;
      case (sel_q)
        SEL_DS1: next_sel = SEL_DS2;
        SEL_DS2: next_sel = SEL_DS3;
        default: next_sel = SEL_DS1;
      endcase
    end
  end

  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    mode_d = mode;

    case (mode)
      MODE_IDLE: begin
        out_d = 8'h00;
        sel_d = SEL_DS1;
        cnt_d = 4'd0;
      end
      MODE_FWD, MODE_REV: begin
        if (mode != mode_q) begin
          // The change edge is itself the first cycle of the first dwell
          out_d = first_data;
          if (neff_m1 == 4'd0) begin
            sel_d = second_sel;
            cnt_d = 4'd0;
          end else begin
            sel_d = first_sel;
            cnt_d = 4'd1;
          end
        end else begin
          out_d = cur_data;
          if (cnt_q >= neff_m1) begin
            cnt_d = 4'd0;
            sel_d = next_sel;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      MODE_FREEZE: begin
        out_d = out_q;
      end
      default: begin
        out_d = out_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= SEL_DS1;
      cnt_q  <= 4'd0;
      mode_q <= MODE_IDLE;
      out_q  <= 8'h00;
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      out_q  <= out_d;
    end
  end

  assign output_data = out_q;

endmodule

// File: tb/tb_data_multiplex.sv
// tb/tb_data_multiplex.sv - directed self-checking bench for data_multiplex
module tb_data_multiplex;

  logic       clk;
  logic       rst_n;
  logic [7:0] DS1, DS2, DS3;
  logic [1:0] mode;
  logic [3:0] switch_clk_cycles;
  logic [7:0] output_data;

  int n_checks = 0;
  int n_pass   = 0;

  data_multiplex dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .DS1               (DS1),
    .DS2               (DS2),
    .DS3               (DS3),
    .mode              (mode),
    .switch_clk_cycles (switch_clk_cycles),
    .output_data       (output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance n rising edges, checking the output on each following falling edge
  task automatic run_edges(input string tag, input int n, input logic [7:0] exp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), output_data, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    DS1 = 8'hAA; DS2 = 8'hBB; DS3 = 8'hCC;
    mode = 2'b01;
    switch_clk_cycles = 4'd6;
    @(negedge clk);
    check("reset_out", output_data, 8'h00);
    @(negedge clk);
    check("reset_hold", output_data, 8'h00);
    rst_n = 1'b1;

    // Forward rotation, N=6, first edge after release is a change edge
    run_edges("fwd_ds1", 6, 8'hAA);
    run_edges("fwd_ds2", 6, 8'hBB);
    run_edges("fwd_ds3", 6, 8'hCC);
    run_edges("fwd_wrap", 1, 8'hAA);

    // Live data: DS1 changes mid-dwell, DS2 changes before its dwell
    DS1 = 8'hDD; DS2 = 8'hEE;
    run_edges("live_ds1", 5, 8'hDD);
    run_edges("live_ds2", 6, 8'hEE);
    run_edges("live_ds3", 3, 8'hCC);

    // Switch to reverse with N=3 mid DS3 dwell
    DS1 = 8'hAA; DS2 = 8'hBB;
    mode = 2'b10; switch_clk_cycles = 4'd3;
    run_edges("rev_ds3", 3, 8'hCC);
    run_edges("rev_ds2", 3, 8'hBB);
    run_edges("rev_ds1", 3, 8'hAA);
    run_edges("rev_wrap", 1, 8'hCC);

    // N=0 behaves as N=1, then N=1 explicitly
    mode = 2'b01; switch_clk_cycles = 4'd0;
    run_edges("n0_a", 1, 8'hAA);
    run_edges("n0_b", 1, 8'hBB);
    run_edges("n0_c", 1, 8'hCC);
    run_edges("n0_a2", 1, 8'hAA);
    switch_clk_cycles = 4'd1;
    run_edges("n1_b", 1, 8'hBB);
    run_edges("n1_c", 1, 8'hCC);
    run_edges("n1_a", 1, 8'hAA);

    // Freeze mid DS2 dwell, then idle, then restart forward
    switch_clk_cycles = 4'd4;
    run_edges("pre_frz", 2, 8'hBB);
    mode = 2'b11; DS2 = 8'h55;
    run_edges("freeze", 10, 8'hBB);
    mode = 2'b00;
    run_edges("idle", 2, 8'h00);
    mode = 2'b01; DS2 = 8'hBB;
    run_edges("restart_ds1", 4, 8'hAA);
    run_edges("restart_ds2", 1, 8'hBB);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", output_data, 8'h00);
    switch_clk_cycles = 4'd2;
    @(posedge clk);
    @(negedge clk);
    check("async_hold", output_data, 8'h00);
    rst_n = 1'b1;
    run_edges("post_ds1", 2, 8'hAA);
    run_edges("post_ds2", 2, 8'hBB);
    run_edges("post_ds3", 2, 8'hCC);

    // Shrinking N mid-dwell advances at the next edge once cnt >= Neff-1
    switch_clk_cycles = 4'd5;
    run_edges("shrink_pre", 3, 8'hAA);
    switch_clk_cycles = 4'd2;
    run_edges("shrink_last", 1, 8'hAA);
    run_edges("shrink_ds2", 2, 8'hBB);
    run_edges("shrink_ds3", 1, 8'hCC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_multiplex.md
# data_multiplex

Time-division multiplexer that places one of three 8-bit data sources (DS1, DS2, DS3) on a single registered output. It rotates through the sources in a mode-selected order, dwelling on each for a programmable number of clock cycles. It sits between several parallel data producers and a shared single-lane consumer.

## Interface
- No parameters; data width is fixed at 8 bits and dwell width at 4 bits.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- DS1  input  8  source 1 data, sampled live at each edge.
- DS2  input  8  source 2 data, sampled live at each edge.
- DS3  input  8  source 3 data, sampled live at each edge.
- mode  input  2  operating mode: 00 idle, 01 forward rotation, 10 reverse rotation, 11 freeze.
- switch_clk_cycles  input  4  dwell length N in cycles per source; 0 is treated as 1.
- output_data  output  8  registered multiplexed data.

## Operation
- Internal state:
  - sel: current source, DS1/DS2/DS3.
  - cnt: 4-bit dwell counter.
  - mode_q: mode registered on the previous edge.
- Neff = (switch_clk_cycles == 0) ? 1 : switch_clk_cycles.
- Source order by mode:
  - Mode 01 (forward): DS1 -> DS2 -> DS3 -> DS1 ...; first source DS1.
  - Mode 10 (reverse): DS3 -> DS2 -> DS1 -> DS3 ...; first source DS3.
- Normal rotation edge (mode 01/10, mode == mode_q):
  - output_data <= value of source sel at that edge.
  - If cnt >= Neff-1: cnt <= 0 and sel <= next source in the order.
  - Otherwise: cnt <= cnt+1.
- Mode-change edge (mode is 01/10 and mode != mode_q):
  - Restart the sequence: output_data <= first source of the new mode.
  - If Neff == 1: sel <= second source, cnt <= 0.
  - Otherwise: sel <= first source, cnt <= 1.
  - The change edge counts as the first dwell cycle.
- Mode 00 (idle):
  - output_data <= 8'h00.
  - sel <= DS1, cnt <= 0.
- Mode 11 (freeze): output_data, sel and cnt all hold.
- Leaving 00 or 11 into 01/10 is a mode change and restarts the sequence.
- mode_q <= mode on every edge.
- Changing switch_clk_cycles mid-dwell takes effect immediately through the >= compare:
  - If the new Neff-1 <= cnt, the source advances at the next edge.
  - The dwell is never extended past the new Neff.

## Timing
- Reset (rst_n low, asynchronous): output_data = 8'h00, sel = DS1, cnt = 0, mode_q = 2'b00. The state holds while rst_n is low.
- Reset release mid-rotation restarts cleanly: because mode_q = 00, the first edge with mode 01/10 is a mode-change edge.
- Latency: one cycle. A source value present before edge k appears on output_data after edge k.
- Source data is not latched at switch time: changes on the selected DS input appear on the output on the next edge.
- Dwell: each source is output on exactly Neff consecutive edges, so one full rotation is 3*Neff edges.
- With Neff = 1 the output changes source on every edge.
- No handshake; output_data is valid every cycle after reset.

## Test plan
- Reset, then mode=01, N=6, DS1=AA, DS2=BB, DS3=CC. Mode 01 is held through reset and release, so mode_q=00 makes edge 1 a mode-change edge. Edges 1-6 -> AA, edges 7-12 -> BB, edges 13-18 -> CC, edge 19 -> AA.
- Live data: mode=01, N=6, DS1 changed AA->DD during the DS1 dwell -> output becomes DD on the next edge. DS2 changed to EE before its dwell -> the BB phase outputs EE.
- Mode switch: mid-rotation in mode 01, set mode=10 and N=3 -> on the change edge output = DS3 (CC). It holds CC 3 edges total, then DS2 for 3 edges, then DS1 for 3 edges, then repeats.
- N=0 and N=1: mode=01 -> output alternates AA, BB, CC, AA on consecutive edges.
- Mode 11 then 00: freeze mid-dwell -> output and counter hold for 10 cycles. Mode 00 -> output 00 on the next edge. Return to 01 -> AA on the change edge.
- Asynchronous reset: assert rst_n=0 between edges mid-rotation -> output_data 00 immediately. After release with mode=01, N=2 -> AA, AA, BB, BB, CC, CC.
